// File: rtl/router_pkg.sv
// Shared router types and default sizing for the input-unit blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package router_pkg;

  localparam int DEF_NUM_VCS  = 4;
  localparam int DEF_VC_DEPTH = 8;
  localparam int FLIT_W       = `FLIT_DATA_WIDTH;

  typedef logic [$clog2(DEF_NUM_VCS)-1:0] vc_id_t;
  typedef logic [FLIT_W-1:0]              flit_t;

endpackage

// File: rtl/vc_fifo_slice.sv
// One virtual-channel FIFO: storage, read/write pointers, exact occupancy count.
// Latency: pushed flit appears at head_data one cycle later; head is first-word-fall-through.
// Backpressure: push to a full slice is refused unless a pop is accepted in the same cycle.
module vc_fifo_slice #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] indata,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  push_ok,
  output logic                  pop_ok
);

  localparam int                   PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  // Status comes from the count alone, so depth need not be a power of two.
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop never sees a flit written in the same cycle (no bypass).
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = empty ? '0 : mem[rd_ptr];

  // Flit storage is intentionally not reset; the count masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= indata;
  end

  // Pointer and occupancy bookkeeping with explicit wrap at DEPTH-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-input-port buffer of NUM_VCS independent VC FIFOs with one write and one read port.
// Latency: flit visible at head one cycle after push; credit returned one cycle after each pop.
// Backpressure: pushes to a full VC are dropped and flagged; upstream is expected to obey credits.
module vc_input_buffer
  import router_pkg::*;
#(
  parameter int NUM_VCS      = DEF_NUM_VCS,
  parameter int VC_DEPTH     = DEF_VC_DEPTH,
  parameter int DATA_WIDTH   = `FLIT_DATA_WIDTH,
  parameter int AFULL_THRESH = VC_DEPTH - 1,
  parameter int VC_ID_WIDTH  = $clog2(NUM_VCS),
  parameter int CNT_WIDTH    = $clog2(VC_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [VC_ID_WIDTH-1:0]          push_vc,
  input  logic [DATA_WIDTH-1:0]           indata,
  input  logic                            pop,
  input  logic [VC_ID_WIDTH-1:0]          pop_vc,
  output logic [NUM_VCS*DATA_WIDTH-1:0]   head_data,
  output logic [NUM_VCS-1:0]              empty,
  output logic [NUM_VCS-1:0]              full,
  output logic [NUM_VCS-1:0]              almost_full,
  output logic [NUM_VCS*CNT_WIDTH-1:0]    count,
  output logic                            credit_valid,
  output logic [VC_ID_WIDTH-1:0]          credit_vc,
  output logic [NUM_VCS-1:0]              overflow_err,
  output logic [NUM_VCS-1:0]              underflow_err
);

  logic [NUM_VCS-1:0] push_sel;
  logic [NUM_VCS-1:0] pop_sel;
  logic [NUM_VCS-1:0] push_ok;
  logic [NUM_VCS-1:0] pop_ok;

  // Demux requests by VC id; ids at or above NUM_VCS select nothing and are ignored.
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign push_sel[v] = push && (push_vc == VC_ID_WIDTH'(v));
    assign pop_sel[v]  = pop  && (pop_vc  == VC_ID_WIDTH'(v));

    vc_fifo_slice #(
      .DEPTH      (VC_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_slice (
      .clk       (clk),
      .reset     (reset),
      .push      (push_sel[v]),
      .pop       (pop_sel[v]),
      .indata    (indata),
      .head_data (head_data[v*DATA_WIDTH +: DATA_WIDTH]),
      .empty     (empty[v]),
      .full      (full[v]),
      .count     (count[v*CNT_WIDTH +: CNT_WIDTH]),
      .push_ok   (push_ok[v]),
      .pop_ok    (pop_ok[v])
    );

    assign almost_full[v] = (count[v*CNT_WIDTH +: CNT_WIDTH] >= CNT_WIDTH'(AFULL_THRESH));
  end

  // Registered credit return; credit_vc holds its last value between credits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_valid <= 1'b0;
      credit_vc    <= '0;
    end else begin
      credit_valid <= |pop_ok;
      if (|pop_ok) credit_vc <= pop_vc;
    end
  end

  // Sticky error flags for refused requests; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_err  <= '0;
      underflow_err <= '0;
    end else begin
      overflow_err  <= overflow_err  | (push_sel & ~push_ok);
      underflow_err <= underflow_err | (pop_sel  & ~pop_ok);
    end
  end

endmodule
